// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: controller state and queued fetch entry.
// Entry fields are sized for the default 32-bit PC/instruction; widen here for larger configurations.
package fetch_pkg;

  localparam int FETCH_PC_W    = 32;
  localparam int FETCH_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch queue with a registered head; push and pop may coincide when full.
// Flush empties the queue in one cycle and overrides push/pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_ent,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  logic [1:0]   r_count;
  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic         w_pop;
  logic         w_push;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_head;

  // Requests that cannot be honoured are dropped here so the storage never corrupts.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (o_empty) r_head <= i_push_ent;
          else         r_tail <= i_push_ent;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (o_full) begin
            r_head <= r_tail;
            r_tail <= i_push_ent;
          end else begin
            r_head <= i_push_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks PC through external combinational imem into a 2-entry queue.
// One cycle PC-to-instrValid, one instruction per cycle; stalls PC while the queue is full.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                           PC_WIDTH          = 32,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter int                           MEMORY_SIZE       = 1024,
  parameter logic [PC_WIDTH-1:0]          START_PC          = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR        = '1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [PC_WIDTH-1:0]          imemAddr,
  input  logic [INSTRUCTION_WIDTH-1:0] imemInstr,
  input  logic                         branchValid,
  input  logic [PC_WIDTH-1:0]          branchTarget,
  output logic                         instrValid,
  output logic [INSTRUCTION_WIDTH-1:0] instrOut,
  output logic [PC_WIDTH-1:0]          pcOut,
  input  logic                         instrReady,
  output logic                         busy,
  output logic                         halted,
  output logic                         addrError
);

  // One extra bit so MEMORY_SIZE == 2**PC_WIDTH still compares correctly.
  localparam logic [PC_WIDTH:0] MEM_LIMIT = (PC_WIDTH + 1)'(MEMORY_SIZE);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                r_addr_err;
  logic                w_addr_err_nxt;

  logic         w_push;
  logic         w_flush;
  logic         w_pop_req;
  logic         w_full;
  logic         w_empty;
  logic         w_in_range;
  logic         w_is_halt;
  fetch_entry_t w_push_ent;
  fetch_entry_t w_head;

  assign w_pop_req  = ~w_empty & instrReady;
  assign w_in_range = ({1'b0, r_pc} < MEM_LIMIT);
  assign w_is_halt  = (imemInstr == HALT_INSTR);

  assign w_push_ent.pc    = FETCH_PC_W'(r_pc);
  assign w_push_ent.instr = FETCH_INSTR_W'(imemInstr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= START_PC;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_addr_err_nxt = r_addr_err;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_state_nxt    = FETCH;
          w_pc_nxt       = START_PC;
          w_addr_err_nxt = 1'b0;
        end
      end
      FETCH: begin
        if (branchValid) begin
          w_flush  = 1'b1;
          w_pc_nxt = branchTarget;
        end else if (!w_in_range) begin
          w_addr_err_nxt = 1'b1;
          w_state_nxt    = DRAIN;
        end else if (!w_full || w_pop_req) begin
          // HALT is consumed here: PC stays on it and it never enters the queue.
          if (w_is_halt) begin
            w_state_nxt = DRAIN;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + PC_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (branchValid) begin
          w_flush     = 1'b1;
          w_pc_nxt    = branchTarget;
          w_state_nxt = FETCH;
        end else if (w_empty) begin
          w_state_nxt = HALTED;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_ent (w_push_ent),
    .i_pop      (w_pop_req & ~w_flush),
    .i_flush    (w_flush),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  assign imemAddr   = r_pc;
  assign instrValid = ~w_empty;
  assign instrOut   = INSTRUCTION_WIDTH'(w_head.instr);
  assign pcOut      = PC_WIDTH'(w_head.pc);
  assign busy       = (r_state == FETCH) || (r_state == DRAIN);
  assign halted     = (r_state == HALTED);
  assign addrError  = r_addr_err;

endmodule
